pm_cycle: RTL and testbench

Parametrised, fully synchronous cycle controller for the P-M unit. Generates the KC (cycle end) and PC (cycle start) pulses from tick counters instead of univibrators. Holds the START, WAIT and CYCLE run-state flags and decides at each cycle end between panel state P0 (sp0), instruction fetch (sp1) and interrupt receive (si1). Interrupt receive is selected from IRQ_N masked request lines with fixed priority.

---
 rtl/pm_cycle.sv | 169 ++++++++++++++++
 tb/tb_pm_cycle.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pm_cycle.sv
// rtl/pm_cycle.sv - P-M cycle controller: KC/PC pulse timing, run-state flags, interrupt receive select
module pm_cycle #(
    parameter int KC_TICKS  = 3,
    parameter int PC_TICKS  = 2,
    parameter int IRQ_N     = 4,
    parameter int IRQ_IDX_W = 2
) (
    input  logic                 __clk,
    input  logic                 clm_,
    input  logic                 start,
    input  logic                 pon,
    input  logic                 work,
    input  logic                 stop,
    input  logic                 hlt,
    input  logic                 wx,
    input  logic                 cycle,
    input  logic                 ekc,
    input  logic [IRQ_N-1:0]     irq,
    input  logic [IRQ_N-1:0]     irq_mask,
    input  logic                 p,
    input  logic                 mc_0,
    output logic                 run,
    output logic                 _wait,
    output logic                 kc,
    output logic                 pc,
    output logic                 sp0,
    output logic                 sp1,
    output logic                 si1,
    output logic                 przerw,
    output logic [IRQ_IDX_W-1:0] irq_idx,
    output logic                 irq_ack
);

    localparam int MAX_TICKS = (KC_TICKS > PC_TICKS) ? KC_TICKS : PC_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS) + 1;
    localparam logic [CNT_W-1:0] KC_LAST = CNT_W'(KC_TICKS - 1);
    localparam logic [CNT_W-1:0] PC_LAST = CNT_W'(PC_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_KC,
        S_PC
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 pr;
    logic                 ekc_pend;
    logic                 start_f;
    logic                 wait_f;
    logic                 cycle_f;
    logic                 pc_first;
    logic                 dpr;
    logic                 dprzerw;
    logic [IRQ_N-1:0]     pend;
    logic [IRQ_IDX_W-1:0] first_idx;

    assign pend     = irq & irq_mask;
    assign run      = start_f & ~wait_f;
    assign _wait    = wait_f;
    assign dpr      = run | cycle_f;
    assign dprzerw  = (cycle_f | start_f) & (|pend) & ~p & mc_0;
    assign pc_first = (state == S_PC) && (cnt == '0);

    assign sp0 = pc & ~pr & ~przerw;
    assign sp1 = pc & pr & ~przerw;
    assign si1 = pc & przerw;

    // Scan downward so the lowest set index is the one left standing
    always_comb begin
        first_idx = irq_idx;
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            if (pend[i]) begin
                first_idx = IRQ_IDX_W'(i);
            end
        end
    end

    always_ff @(posedge __clk or negedge clm_) begin
        if (!clm_) begin
            start_f <= 1'b0;
            wait_f  <= 1'b0;
            cycle_f <= 1'b0;
        end else begin
            if (stop) begin
                start_f <= 1'b0;
            end else if (start && pon && work) begin
                start_f <= 1'b1;
            end

            if (stop || si1) begin
                wait_f <= 1'b0;
            end else if (hlt && wx) begin
                wait_f <= 1'b1;
            end

            // A fresh panel request is kept even if it lands on the consuming clock
            if (cycle) begin
                cycle_f <= 1'b1;
            end else if (pc_first && (pr || przerw)) begin
                cycle_f <= 1'b0;
            end
        end
    end

    always_ff @(posedge __clk or negedge clm_) begin
        if (!clm_) begin
            state    <= S_IDLE;
            cnt      <= '0;
            kc       <= 1'b0;
            pc       <= 1'b0;
            pr       <= 1'b0;
            przerw   <= 1'b0;
            irq_idx  <= '0;
            irq_ack  <= 1'b0;
            ekc_pend <= 1'b0;
        end else begin
            irq_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ekc) begin
                        state    <= S_KC;
                        kc       <= 1'b1;
                        cnt      <= '0;
                        ekc_pend <= 1'b0;
                    end
                end
                S_KC: begin
                    if (cnt == KC_LAST) begin
                        state   <= S_PC;
                        kc      <= 1'b0;
                        pc      <= 1'b1;
                        cnt     <= '0;
                        pr      <= dpr;
                        przerw  <= dprzerw;
                        irq_idx <= first_idx;
                        irq_ack <= dprzerw;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PC: begin
                    if (cnt == PC_LAST) begin
                        pc  <= 1'b0;
                        cnt <= '0;
                        if (ekc_pend || ekc) begin
                            state    <= S_KC;
                            kc       <= 1'b1;
                            ekc_pend <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (ekc) begin
                            ekc_pend <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    kc    <= 1'b0;
                    pc    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pm_cycle.sv
// tb/tb_pm_cycle.sv - directed vector bench for pm_cycle
module tb_pm_cycle;

    logic       clk = 1'b0;
    logic       clm_;
    logic       start, pon, work, stop, hlt, wx, cycle, ekc, p, mc_0;
    logic [3:0] irq, irq_mask;
    logic       run, wait_o, kc, pc, sp0, sp1, si1, przerw, irq_ack;
    logic [1:0] irq_idx;

    int n_pass = 0;
    int n_total = 0;

    pm_cycle #(
        .KC_TICKS(3), .PC_TICKS(2), .IRQ_N(4), .IRQ_IDX_W(2)
    ) dut (
        .__clk(clk), .clm_(clm_), .start(start), .pon(pon), .work(work),
        .stop(stop), .hlt(hlt), .wx(wx), .cycle(cycle), .ekc(ekc),
        .irq(irq), .irq_mask(irq_mask), .p(p), .mc_0(mc_0),
        .run(run), ._wait(wait_o), .kc(kc), .pc(pc), .sp0(sp0), .sp1(sp1),
        .si1(si1), .przerw(przerw), .irq_idx(irq_idx), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    // ctl = {ekc,start,pon,work,stop,hlt,wx,cycle,p,mc_0}
    localparam logic [9:0] C_IDLE  = 10'b0011000001;
    localparam logic [9:0] C_EKC   = 10'b1011000001;
    localparam logic [9:0] C_STNP  = 10'b0101000001;
    localparam logic [9:0] C_START = 10'b0111000001;
    localparam logic [9:0] C_HLTWX = 10'b0011011001;
    localparam logic [9:0] C_EKCP  = 10'b1011000011;
    localparam logic [9:0] C_IDLEP = 10'b0011000011;
    localparam logic [9:0] C_STOP  = 10'b0011100001;
    localparam logic [9:0] C_CYCLE = 10'b0011000101;

    // exp = {kc,pc,sp0,sp1,si1,przerw,irq_ack,irq_idx[1:0],run,_wait}
    typedef struct {
        logic [9:0]  ctl;
        logic [3:0]  irq;
        logic [3:0]  mask;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [10:0] obs();
        return {kc, pc, sp0, sp1, si1, przerw, irq_ack, irq_idx, run, wait_o};
    endfunction

    task automatic add(input logic [9:0] c, input logic [3:0] i, input logic [3:0] m,
                       input logic [10:0] e);
        vec_t v;
        v.ctl = c; v.irq = i; v.mask = m; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [9:0] c, input logic [3:0] i, input logic [3:0] m);
        {ekc, start, pon, work, stop, hlt, wx, cycle, p, mc_0} = c;
        irq = i;
        irq_mask = m;
    endtask

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%b expected=%b", name, act, exp);
    endtask

    initial begin
        // Plain idle cycle: sp0 for both PC clocks
        add(C_EKC,   4'h0, 4'h0, 11'b1_0_0_0_0_0_0_00_0_0);
        add(C_IDLE,  4'h0, 4'h0, 11'b1_0_0_0_0_0_0_00_0_0);
        add(C_IDLE,  4'h0, 4'h0, 11'b1_0_0_0_0_0_0_00_0_0);
        add(C_IDLE,  4'h0, 4'h0, 11'b0_1_1_0_0_0_0_00_0_0);
        add(C_IDLE,  4'h0, 4'h0, 11'b0_1_1_0_0_0_0_00_0_0);
        add(C_IDLE,  4'h0, 4'h0, 11'b0_0_0_0_0_0_0_00_0_0);
        // start without pon is ignored, then a real start
        add(C_STNP,  4'h0, 4'h0, 11'b0_0_0_0_0_0_0_00_0_0);
        add(C_START, 4'h0, 4'h0, 11'b0_0_0_0_0_0_0_00_1_0);
        add(C_EKC,   4'h0, 4'h0, 11'b1_0_0_0_0_0_0_00_1_0);
        add(C_IDLE,  4'h0, 4'h0, 11'b1_0_0_0_0_0_0_00_1_0);
        add(C_IDLE,  4'h0, 4'h0, 11'b1_0_0_0_0_0_0_00_1_0);
        add(C_IDLE,  4'h0, 4'h0, 11'b0_1_0_1_0_0_0_00_1_0);
        add(C_IDLE,  4'h0, 4'h0, 11'b0_1_0_1_0_0_0_00_1_0);
        add(C_IDLE,  4'h0, 4'h0, 11'b0_0_0_0_0_0_0_00_1_0);
        // halt: WAIT set, run drops, next cycle goes to P0
        add(C_HLTWX, 4'h0, 4'h0, 11'b0_0_0_0_0_0_0_00_0_1);
        add(C_EKC,   4'h0, 4'h0, 11'b1_0_0_0_0_0_0_00_0_1);
        add(C_IDLE,  4'h0, 4'h0, 11'b1_0_0_0_0_0_0_00_0_1);
        add(C_IDLE,  4'h0, 4'h0, 11'b1_0_0_0_0_0_0_00_0_1);
        add(C_IDLE,  4'h0, 4'h0, 11'b0_1_1_0_0_0_0_00_0_1);
        add(C_IDLE,  4'h0, 4'h0, 11'b0_1_1_0_0_0_0_00_0_1);
        add(C_IDLE,  4'h0, 4'h0, 11'b0_0_0_0_0_0_0_00_0_1);
        // interrupt receive: pend=0100 -> idx 2, ack on first PC, WAIT cleared
        add(C_EKC,   4'h6, 4'h4, 11'b1_0_0_0_0_0_0_00_0_1);
        add(C_IDLE,  4'h6, 4'h4, 11'b1_0_0_0_0_0_0_00_0_1);
        add(C_IDLE,  4'h6, 4'h4, 11'b1_0_0_0_0_0_0_00_0_1);
        add(C_IDLE,  4'h6, 4'h4, 11'b0_1_0_0_1_1_1_10_0_1);
        add(C_IDLE,  4'h6, 4'h4, 11'b0_1_0_0_1_1_0_10_1_0);
        add(C_IDLE,  4'h6, 4'h4, 11'b0_0_0_0_0_1_0_10_1_0);
        // branch indicator blocks acceptance -> fetch
        add(C_EKCP,  4'h6, 4'h4, 11'b1_0_0_0_0_1_0_10_1_0);
        add(C_IDLEP, 4'h6, 4'h4, 11'b1_0_0_0_0_1_0_10_1_0);
        add(C_IDLEP, 4'h6, 4'h4, 11'b1_0_0_0_0_1_0_10_1_0);
        add(C_IDLEP, 4'h6, 4'h4, 11'b0_1_0_1_0_0_0_10_1_0);
        add(C_IDLEP, 4'h6, 4'h4, 11'b0_1_0_1_0_0_0_10_1_0);
        add(C_IDLEP, 4'h6, 4'h4, 11'b0_0_0_0_0_0_0_10_1_0);
        // stop, single CYCLE: one fetch, then P0; idx held with pend=0
        add(C_STOP,  4'h0, 4'h0, 11'b0_0_0_0_0_0_0_10_0_0);
        add(C_CYCLE, 4'h0, 4'h0, 11'b0_0_0_0_0_0_0_10_0_0);
        add(C_EKC,   4'h0, 4'h0, 11'b1_0_0_0_0_0_0_10_0_0);
        add(C_IDLE,  4'h0, 4'h0, 11'b1_0_0_0_0_0_0_10_0_0);
        add(C_IDLE,  4'h0, 4'h0, 11'b1_0_0_0_0_0_0_10_0_0);
        add(C_IDLE,  4'h0, 4'h0, 11'b0_1_0_1_0_0_0_10_0_0);
        add(C_IDLE,  4'h0, 4'h0, 11'b0_1_0_1_0_0_0_10_0_0);
        add(C_IDLE,  4'h0, 4'h0, 11'b0_0_0_0_0_0_0_10_0_0);
        add(C_EKC,   4'h0, 4'h0, 11'b1_0_0_0_0_0_0_10_0_0);
        add(C_IDLE,  4'h0, 4'h0, 11'b1_0_0_0_0_0_0_10_0_0);
        add(C_IDLE,  4'h0, 4'h0, 11'b1_0_0_0_0_0_0_10_0_0);
        add(C_IDLE,  4'h0, 4'h0, 11'b0_1_1_0_0_0_0_10_0_0);
        add(C_IDLE,  4'h0, 4'h0, 11'b0_1_1_0_0_0_0_10_0_0);
        add(C_IDLE,  4'h0, 4'h0, 11'b0_0_0_0_0_0_0_10_0_0);

        clm_ = 1'b0;
        drive(C_IDLE, 4'h0, 4'h0);
        repeat (2) @(negedge clk);
        check("reset_state", obs(), 11'b0);
        clm_ = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].ctl, tbl[i].irq, tbl[i].mask);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", i), obs(), tbl[i].exp);
        end

        // ekc during PC chains straight into KC; ekc during KC is dropped
        begin
            logic       s_ekc [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            logic [1:0] s_exp [12] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10,
                                       2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00};
            for (int k = 0; k < 12; k++) begin
                drive(C_IDLE, 4'h0, 4'h0);
                ekc = s_ekc[k];
                @(posedge clk);
                @(negedge clk);
                check($sformatf("chain%0d", k), {9'b0, kc, pc}, {9'b0, s_exp[k]});
            end
        end

        // asynchronous clear mid-KC aborts the cycle
        drive(C_START, 4'h0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        drive(C_EKC, 4'h0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        check("kc_before_clear", obs(), 11'b1_0_0_0_0_0_0_10_1_0);
        drive(C_IDLE, 4'h0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        #2 clm_ = 1'b0;
        #1 check("async_clear", obs(), 11'b0);
        @(negedge clk);
        clm_ = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("post_clear%0d", k), {kc, pc, sp0, sp1, si1, 6'b0},
                  11'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
